// File: rtl/carry_resolve_pkg.sv
// -----------------------------------------------------------------------------
// carry_resolve_pkg
//   Shared definitions for the carry-resolving sequencer.
//   - ST_IDLE / ST_RUN / ST_DONE : FSM state encodings
//   - state_e                    : FSM state type built on those encodings
//   - ITER_W(n)                  : width of the step counter for operand width n
//                                  (must hold 0..n+1)
// -----------------------------------------------------------------------------
package carry_resolve_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic int ITER_W(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/carry_resolve_seq_ha_vec_step.sv
// -----------------------------------------------------------------------------
// ha_vec_step
//   One combinational half-adder step over a W-bit (sum, carry) pair.
//   The pair's arithmetic value s + c is preserved modulo 2^W.
//   Ports:
//     i_s     [W-1:0]  current partial sum
//     i_c     [W-1:0]  current carry vector (already at its bit weight)
//     o_s_nxt [W-1:0]  i_s ^ i_c
//     o_c_nxt [W-1:0]  (i_s & i_c) << 1, truncated to W bits
// -----------------------------------------------------------------------------
module ha_vec_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s_nxt,
  output logic [W-1:0] o_c_nxt
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign o_s_nxt[gi] = i_s[gi] ^ i_c[gi];
      if (gi == 0) begin : g_lsb
        assign o_c_nxt[gi] = 1'b0;
      end else begin : g_upper
        // Carry out of bit gi-1 lands at bit gi; the carry out of the
        // MSB is dropped, which is safe because the true total fits.
        assign o_c_nxt[gi] = i_s[gi-1] & i_c[gi-1];
      end
    end
  endgenerate

endmodule

// File: rtl/carry_resolve_seq.sv
// -----------------------------------------------------------------------------
// carry_resolve_seq
//   Turns a half-adder (sum, cout) vector pair into a binary N+1-bit total by
//   applying one half-adder step per clock until the carry vector is zero.
//   Single-entry, valid/ready on both sides.
//
//   Optional feature macro: CARRY_RESOLVE_ITER_EN
//     When defined, adds iter_cnt (number of steps taken) and iter_err
//     (sticky flag if the step count would exceed N+1; cleared by reset only).
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      synchronous active-low reset
//     in_valid   sum_in/cout_in valid
//     in_ready   high only in IDLE
//     sum_in     [N-1:0] half-adder sum vector
//     cout_in    [N-1:0] half-adder carry vector (bit i weighs 2^(i+1))
//     out_valid  high only in DONE
//     out_ready  downstream accepts result
//     result     [N:0]   resolved total, driven from s in every state
//     iter_cnt   [ITER_W(N)-1:0] steps taken (macro only)
//     iter_err   step-bound violation, sticky (macro only)
// -----------------------------------------------------------------------------
module carry_resolve_seq
  import carry_resolve_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           sum_in,
  input  logic [N-1:0]           cout_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N:0]             result
`ifdef CARRY_RESOLVE_ITER_EN
  ,
  output logic [ITER_W(N)-1:0]   iter_cnt,
  output logic                   iter_err
`endif
);

  localparam int IW = ITER_W(N);
  localparam logic [IW-1:0] ITER_MAX = IW'(N + 1);

  state_e        r_state;
  state_e        w_state_next;
  logic [N:0]    r_s;
  logic [N:0]    r_c;
  logic [IW-1:0] r_iter;
  logic [N:0]    w_s_next;
  logic [N:0]    w_c_next;
  logic [IW-1:0] w_iter_next;
  logic [N:0]    w_s_step;
  logic [N:0]    w_c_step;

  ha_vec_step #(.W(N + 1)) u_step (
    .i_s     (r_s),
    .i_c     (r_c),
    .o_s_nxt (w_s_step),
    .o_c_nxt (w_c_step)
  );

  // Next-state and datapath-next logic.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_c_next     = r_c;
    w_iter_next  = r_iter;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_s_next     = {1'b0, sum_in};
          w_c_next     = {cout_in, 1'b0};
          w_iter_next  = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_c == '0) begin
          w_state_next = DONE;
        end else begin
          w_s_next = w_s_step;
          w_c_next = w_c_step;
          // Counter saturates at the bound rather than wrapping, so
          // iter_cnt never reports a misleadingly small value.
          if (r_iter != ITER_MAX) begin
            w_iter_next = r_iter + IW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_c     <= w_c_next;
      r_iter  <= w_iter_next;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_s;

`ifdef CARRY_RESOLVE_ITER_EN
  logic r_err;

  // A step requested while the counter already sits at N+1 would exceed
  // the theoretical maximum chain length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == RUN && r_c != '0 && r_iter == ITER_MAX) begin
      r_err <= 1'b1;
    end
  end

  assign iter_cnt = r_iter;
  assign iter_err = r_err;
`endif

endmodule

// File: tb/tb_carry_resolve_seq.sv
module tb_carry_resolve_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [N-1:0] sum_in = '0;
  logic [N-1:0] cout_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [N:0] result;
`ifdef CARRY_RESOLVE_ITER_EN
  logic [2:0] iter_cnt;
  logic       iter_err;
`endif

  carry_resolve_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef CARRY_RESOLVE_ITER_EN
    ,
    .iter_cnt  (iter_cnt),
    .iter_err  (iter_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N:0] res;
    int         iter;   // -1: step count not checked
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int accepts = 0;
  int pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  // Present one operand pair and wait for the accepting edge; the expected
  // response is queued for the monitor once acceptance is certain.
  task automatic send(input logic [N-1:0] s, input logic [N-1:0] co,
                      input logic [N:0] er, input int ei, input string nm,
                      output bit ok);
    @(negedge clk);
    sum_in   = s;
    cout_in  = co;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_%s actual=not_accepted required=accepted", nm);
    end else begin
      sb.push_back('{er, ei, nm});
      accepts++;
      @(posedge clk);
    end
  endtask

  // Called right after the accepting edge. n counts edges with the accepting
  // edge itself as edge 1, ending at the edge after which out_valid is high.
  task automatic wait_valid(input string nm, output int n);
    bit seen;
    n = 1;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout_%s actual=no_out_valid required=out_valid", nm);
    end
  endtask

  // Monitor: every output handshake pops and compares one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0d required=no_output", result);
        end else begin
          e = sb.pop_front();
          pops++;
          check({e.name, "_result"}, 32'(result), 32'(e.res));
`ifdef CARRY_RESOLVE_ITER_EN
          if (e.iter >= 0) begin
            check({e.name, "_iter_cnt"}, 32'(iter_cnt), 32'(e.iter));
            check({e.name, "_iter_err"}, 32'(iter_err), 32'd0);
          end
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bit stale;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
`ifdef CARRY_RESOLVE_ITER_EN
    check("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    check("rst_iter_err", 32'(iter_err), 32'd0);
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 1: no carries, k=0
    send(4'b1111, 4'b0000, 5'd15, 0, "c1", ok);
    #1 in_valid = 1'b0;
    if (ok) begin
      wait_valid("c1", n);
      check("c1_latency", 32'(n), 32'd2);
    end

    // 2: one step, k=1
    send(4'b0000, 4'b1111, 5'd30, 1, "c2", ok);
    #1 in_valid = 1'b0;
    if (ok) begin
      wait_valid("c2", n);
      check("c2_latency", 32'(n), 32'd3);
    end

    // 3: worst-case ripple chain, k=4
    send(4'b1110, 4'b0001, 5'd16, 4, "c3", ok);
    #1 in_valid = 1'b0;
    if (ok) begin
      wait_valid("c3", n);
      check("c3_latency", 32'(n), 32'd6);
    end

    // 4: backpressure; a=0110 b=0011 -> 9, k=2
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0101, 4'b0010, 5'd9, 2, "c4", ok);
    #1 in_valid = 1'b0;
    if (ok) begin
      wait_valid("c4", n);
      check("c4_latency", 32'(n), 32'd4);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        check("c4_hold_out_valid", 32'(out_valid), 32'd1);
        check("c4_hold_result", 32'(result), 32'd9);
        check("c4_hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("c4_release_in_ready", 32'(in_ready), 32'd1);
      check("c4_release_out_valid", 32'(out_valid), 32'd0);
    end

    // 5: reset while case 3 is stepping
    send(4'b1110, 4'b0001, 5'd16, 4, "c5", ok);
    #1 in_valid = 1'b0;
    if (ok) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      void'(sb.pop_back());  // in-flight operation is dropped
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("c5_in_ready", 32'(in_ready), 32'd1);
      check("c5_out_valid", 32'(out_valid), 32'd0);
      check("c5_result", 32'(result), 32'd0);
`ifdef CARRY_RESOLVE_ITER_EN
      check("c5_iter_cnt", 32'(iter_cnt), 32'd0);
`endif
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        if (out_valid) stale = 1'b1;
      end
      check("c5_no_stale_output", 32'(stale), 32'd0);
    end

    // 6: back-to-back exhaustive sweep of 4-bit a, b
    out_ready = 1'b1;
    begin
      int acc0;
      int pop0;
      acc0 = accepts;
      pop0 = pops;
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          logic [N-1:0] la;
          logic [N-1:0] lb;
          la = a[N-1:0];
          lb = b[N-1:0];
          send(la ^ lb, la & lb, 5'(a + b), -1, $sformatf("sw_%0d_%0d", a, b), ok);
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
      @(negedge clk);
      #2;
      check("sweep_accepts", 32'(accepts - acc0), 32'd256);
      check("sweep_outputs", 32'(pops - pop0), 32'd256);
      check("sweep_queue_empty", 32'(sb.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
